// File: rtl/uart_ascii_pkg.sv
// Shared ASCII constants, parser states and error codes
// for the UART text front end (parser and printer).
package uart_ascii_pkg;

    localparam logic [7:0] CHAR_0     = 8'h30;
    localparam logic [7:0] CHAR_9     = 8'h39;
    localparam logic [7:0] CHAR_MINUS = 8'h2D;
    localparam logic [7:0] CHAR_PLUS  = 8'h2B;
    localparam logic [7:0] CHAR_CR    = 8'h0D;
    localparam logic [7:0] CHAR_LF    = 8'h0A;
    localparam logic [7:0] CHAR_SP    = 8'h20;

    typedef enum logic [1:0] {
        IDLE,
        SIGNED,
        DIGITS,
        ERROR
    } state_t;

    localparam logic [1:0] ERR_BAD   = 2'd1;
    localparam logic [1:0] ERR_OVF   = 2'd2;
    localparam logic [1:0] ERR_EMPTY = 2'd3;

endpackage

// File: rtl/ascii_number_parser.sv
// Decodes ASCII signed decimal tokens from the UART rx stream
// into two's-complement values, with per-token error reporting.
module ascii_number_parser
    import uart_ascii_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int ACCEPT_PLUS = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       rx_data,
    input  logic             new_rx_data,
    output logic [WIDTH-1:0] value,
    output logic             new_value,
    output logic             error,
    output logic [1:0]       err_code,
    output logic             busy
);

    localparam int WW = WIDTH + 4;
    localparam logic [WW-1:0] LIM_NEG = WW'(1) << (WIDTH - 1);
    localparam logic [WW-1:0] LIM_POS = LIM_NEG - WW'(1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic             neg_q, neg_d;
    logic [1:0]       reason_q, reason_d;
    logic [WIDTH-1:0] value_q, value_d;
    logic             new_value_q, new_value_d;
    logic             error_q, error_d;
    logic [1:0]       err_code_q, err_code_d;

    logic          is_digit;
    logic          is_sign;
    logic          is_term;
    logic [3:0]    digit;
    logic [WW-1:0] acc_w;
    logic [WW-1:0] times10;
    logic [WW-1:0] limit;

    // Byte classification and the times-ten-plus-digit datapath
    always_comb begin
        is_digit = (rx_data >= CHAR_0) && (rx_data <= CHAR_9);
        is_sign  = (rx_data == CHAR_MINUS)
                || ((ACCEPT_PLUS != 0) && (rx_data == CHAR_PLUS));
        is_term  = (rx_data == CHAR_CR) || (rx_data == CHAR_LF)
                || (rx_data == CHAR_SP);
        digit    = rx_data[3:0];
        acc_w    = {4'b0000, acc_q};
        times10  = (acc_w << 3) + (acc_w << 1)
                 + {{WIDTH{1'b0}}, digit};
        limit    = neg_q ? LIM_NEG : LIM_POS;
    end

    // Token FSM: next state, accumulator and output pulses
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        neg_d       = neg_q;
        reason_d    = reason_q;
        value_d     = value_q;
        new_value_d = 1'b0;
        error_d     = 1'b0;
        err_code_d  = err_code_q;
        if (new_rx_data) begin
            unique case (state_q)
                IDLE: begin
                    if (is_term) begin
                        state_d = IDLE;
                    end else if (is_sign) begin
                        neg_d   = (rx_data == CHAR_MINUS);
                        acc_d   = '0;
                        state_d = SIGNED;
                    end else if (is_digit) begin
                        neg_d   = 1'b0;
                        acc_d   = {{(WIDTH-4){1'b0}}, digit};
                        state_d = DIGITS;
                    end else begin
                        reason_d = ERR_BAD;
                        state_d  = ERROR;
                    end
                end
                SIGNED: begin
                    if (is_digit) begin
                        acc_d   = {{(WIDTH-4){1'b0}}, digit};
                        state_d = DIGITS;
                    end else if (is_term) begin
                        error_d    = 1'b1;
                        err_code_d = ERR_EMPTY;
                        state_d    = IDLE;
                    end else begin
                        reason_d = ERR_BAD;
                        state_d  = ERROR;
                    end
                end
                DIGITS: begin
                    if (is_digit) begin
                        if (times10 > limit) begin
                            reason_d = ERR_OVF;
                            state_d  = ERROR;
                        end else begin
                            acc_d = times10[WIDTH-1:0];
                        end
                    end else if (is_term) begin
                        value_d     = neg_q ? -acc_q : acc_q;
                        new_value_d = 1'b1;
                        state_d     = IDLE;
                    end else begin
                        reason_d = ERR_BAD;
                        state_d  = ERROR;
                    end
                end
                ERROR: begin
                    if (is_term) begin
                        error_d    = 1'b1;
                        err_code_d = reason_q;
                        state_d    = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            neg_q       <= 1'b0;
            reason_q    <= 2'd0;
            value_q     <= '0;
            new_value_q <= 1'b0;
            error_q     <= 1'b0;
            err_code_q  <= 2'd0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            neg_q       <= neg_d;
            reason_q    <= reason_d;
            value_q     <= value_d;
            new_value_q <= new_value_d;
            error_q     <= error_d;
            err_code_q  <= err_code_d;
        end
    end

    assign value     = value_q;
    assign new_value = new_value_q;
    assign error     = error_q;
    assign err_code  = err_code_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_ascii_number_parser.sv
// Directed scoreboard bench for ascii_number_parser,
// with a second instance built without '+' support.
module tb_ascii_number_parser;

    logic        clk;
    logic        rst;
    logic [7:0]  rx_data;
    logic        new_rx_data;
    logic [31:0] value;
    logic        new_value;
    logic        error;
    logic [1:0]  err_code;
    logic        busy;
    logic [31:0] value_np;
    logic        new_value_np;
    logic        error_np;
    logic [1:0]  err_code_np;
    logic        busy_np;

    typedef struct {
        bit          is_err;
        logic [31:0] data;
        int          due;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;

    ascii_number_parser #(.WIDTH(32), .ACCEPT_PLUS(1)) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data),
        .new_rx_data(new_rx_data), .value(value),
        .new_value(new_value), .error(error),
        .err_code(err_code), .busy(busy)
    );

    ascii_number_parser #(.WIDTH(32), .ACCEPT_PLUS(0)) dut_np (
        .clk(clk), .rst(rst), .rx_data(rx_data),
        .new_rx_data(new_rx_data), .value(value_np),
        .new_value(new_value_np), .error(error_np),
        .err_code(err_code_np), .busy(busy_np)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(logic [7:0] b);
        @(posedge clk);
        #1;
        rx_data     = b;
        new_rx_data = 1'b1;
    endtask

    task automatic send_str(string s);
        for (int i = 0; i < s.len(); i++) send(s[i]);
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            new_rx_data = 1'b0;
            rx_data     = 8'h00;
        end
    endtask

    task automatic exp_val(logic [31:0] v);
        exp_t e;
        e.is_err = 1'b0;
        e.data   = v;
        e.due    = cyc + 1;
        q.push_back(e);
    endtask

    task automatic exp_err(logic [1:0] c);
        exp_t e;
        e.is_err = 1'b1;
        e.data   = {30'd0, c};
        e.due    = cyc + 1;
        q.push_back(e);
    endtask

    // Scoreboard: every pulse must match the oldest expectation
    always @(negedge clk) begin
        if (rst && (new_value || error)) begin
            exp_t e;
            chk("pulse_exclusive", {63'd0, new_value && error}, 64'd0);
            chk("pulse_expected", {63'd0, q.size() != 0}, 64'd1);
            if (q.size() != 0) begin
                e = q.pop_front();
                chk("pulse_kind", {63'd0, error}, {63'd0, e.is_err});
                chk("pulse_cycle", 64'(cyc), 64'(e.due));
                if (e.is_err)
                    chk("err_code", {62'd0, err_code}, {32'd0, e.data});
                else
                    chk("value", {32'd0, value}, {32'd0, e.data});
            end
        end
    end

    initial begin
        rst         = 1'b0;
        rx_data     = 8'h00;
        new_rx_data = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_value", {32'd0, value}, 64'd0);
        chk("rst_new_value", {63'd0, new_value}, 64'd0);
        chk("rst_error", {63'd0, error}, 64'd0);
        chk("rst_err_code", {62'd0, err_code}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        rst = 1'b1;
        idle(2);

        send_str("123\r");
        exp_val(32'd123);
        idle(3);

        send_str("-2147483648 ");
        exp_val(32'h8000_0000);
        send_str("2147483648\n");
        exp_err(2'd2);
        idle(3);
        @(negedge clk);
        chk("ovf_value_hold", {32'd0, value}, 64'h8000_0000);

        send_str("2147483647\r");
        exp_val(32'h7fff_ffff);
        send_str("-\n");
        exp_err(2'd3);
        send_str("12a4\r");
        exp_err(2'd1);
        send_str("7\r");
        exp_val(32'd7);
        send_str("0000000007\r");
        exp_val(32'd7);
        send_str("-0\r");
        exp_val(32'd0);
        send_str("-+3\r");
        exp_err(2'd1);
        idle(3);

        send_str("45");
        idle(1);
        @(negedge clk);
        chk("busy_mid_token", {63'd0, busy}, 64'd1);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("mid_rst_busy", {63'd0, busy}, 64'd0);
        chk("mid_rst_value", {32'd0, value}, 64'd0);
        rst = 1'b1;
        idle(1);
        send_str("6\r");
        exp_val(32'd6);
        idle(3);

        send_str("  \r\n\n  ");
        idle(1);
        @(negedge clk);
        chk("busy_before_sign", {63'd0, busy}, 64'd0);
        send("-");
        idle(1);
        @(negedge clk);
        chk("busy_after_sign", {63'd0, busy}, 64'd1);
        send_str("09\n");
        exp_val(-32'sd9);
        idle(1);
        @(negedge clk);
        chk("busy_after_lf", {63'd0, busy}, 64'd0);
        idle(2);

        send_str("+5\r");
        exp_val(32'd5);
        idle(1);
        @(negedge clk);
        chk("noplus_error", {63'd0, error_np}, 64'd1);
        chk("noplus_code", {62'd0, err_code_np}, 64'd1);
        chk("noplus_no_value", {63'd0, new_value_np}, 64'd0);
        idle(4);

        chk("queue_drained", 64'(q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ascii_number_parser.md
Name: ascii_number_parser

Overview:
- Receive-side companion to the number printer: consumes the UART receiver byte stream (rx_data/new_rx_data) and decodes ASCII signed decimal tokens into a two's-complement binary value.
- Sits between the UART rx and the compute FSM, so operands can be typed as text ("-1234\r") rather than raw bytes.
- Emits one value pulse per well-formed token, or one error pulse per malformed token.

Parameters:
- WIDTH, 32, result width in bits (signed, two's complement).
- ACCEPT_PLUS, 1, when 1 a leading '+' is a legal sign; when 0 it is a bad character.

Ports:
- clk  input  1  system clock
- rst  input  1  reset, asynchronous, active-low
- rx_data  input  8  received byte, valid only when new_rx_data=1
- new_rx_data  input  1  single-cycle strobe per received byte
- value  output  WIDTH  last successfully parsed number (signed); holds until the next success
- new_value  output  1  single-cycle strobe; value is valid in the same cycle
- error  output  1  single-cycle strobe at the end of a malformed token
- err_code  output  2  reason, valid with error: 1=bad char, 2=overflow, 3=empty (sign only); holds until the next error
- busy  output  1  high while a token is in progress (state != IDLE)

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous and active-low.
- Reset values: value=0, new_value=0, error=0, err_code=0, busy=0, state=IDLE, accumulator=0, neg=0.
  - Reset mid-token discards the partial token; no pulse is emitted.
- Byte classes:
  - digit '0'..'9' (0x30-0x39)
  - sign '-' (0x2D); '+' (0x2B) when ACCEPT_PLUS=1
  - terminator CR 0x0D, LF 0x0A, space 0x20
  - anything else is bad
- Bytes are acted on only when new_rx_data=1. All decisions are made in the strobe cycle, and outputs are registered, so latency is 1 cycle.
- State IDLE:
  - terminator: ignored (blank lines and extra spaces produce no output)
  - '-': neg=1, acc=0, cnt=0, go SIGNED
  - '+': neg=0, acc=0, cnt=0, go SIGNED
  - digit d: neg=0, acc=d, cnt=1, go DIGITS
  - bad: err_pend=1 (bad char), go ERROR
- State SIGNED:
  - digit: acc=d, go DIGITS
  - terminator: error pulse with code 3, go IDLE
  - sign or bad: code 1, go ERROR
- State DIGITS:
  - digit: next = acc*10 + d, computed in WIDTH+4 bits as (acc<<3)+(acc<<1)+d.
    - limit = 2^(WIDTH-1) if neg, else 2^(WIDTH-1)-1.
    - next > limit: code 2, go ERROR.
    - otherwise acc=next.
  - terminator: go IDLE. Next cycle value = neg ? -acc : acc (truncated to WIDTH) and new_value=1.
  - sign or bad: code 1, go ERROR.
- State ERROR:
  - Discard every non-terminator byte. The first recorded reason is kept and not overwritten.
  - terminator: error=1 and err_code=reason for one cycle, go IDLE.
- Leading zeros are legal and do not cause overflow ("0000000007" = 7). "-0" yields 0.
- Boundary cases:
  - -2^(WIDTH-1) is representable; +2^(WIDTH-1) is overflow.
  - new_value and error are never high in the same cycle.
  - At most one pulse is emitted per terminator.
  - A byte in the cycle right after a pulse is processed normally, from IDLE.
- busy is combinational from state.

Decomposition:
- Package uart_ascii_pkg holds:
  - ASCII constants (CHAR_0, CHAR_9, CHAR_MINUS, CHAR_PLUS, CHAR_CR, CHAR_LF, CHAR_SP)
  - the state encoding (IDLE, SIGNED, DIGITS, ERROR)
  - error codes (ERR_BAD=1, ERR_OVF=2, ERR_EMPTY=3)
- The printer side shares the ASCII constants from this package.
- No sub-module: the classify, times-10 and limit compare logic is small and lives inline in a single FSM with _d/_q register pairs.

Test Plan:
- "123\r": value=123 and new_value pulses once, 1 cycle after the CR strobe; error never asserts.
- "-2147483648 " then "2147483648\n": first gives value=0x80000000; second gives error=1, err_code=2, no new_value, value stays 0x80000000.
- "-\n" gives err_code=3. Then "12a4\r" gives a single error with err_code=1 only on the CR. Then "7\r" gives value=7.
- Send "45", pulse rst low for 2 cycles, send "6\r": value=6, and no pulse for "45".
- "  \r\n\n  -09\n": exactly one new_value with value=-9; no error pulses; busy low before the '-' and again after the final LF.
- "+5\r" with ACCEPT_PLUS=1 gives value=5. The same input with ACCEPT_PLUS=0 gives err_code=1.
